rst_seq: RTL and testbench
==========================

RST_SEQ -- requirements
Module: rst_seq

Interface
REQ-001 SHALL have parameter N_CH, default 4, number of sequenced reset channels (1..16).
REQ-002 SHALL have parameter LOCK_FILT, default 16, consecutive cycles lock must be stable before sequencing (>=1).
REQ-003 SHALL have parameter STRETCH, default 8, cycles all resets are held after lock qualification (>=1).
REQ-004 SHALL have parameter GAP, default 4, cycles between successive channel releases (>=1).
REQ-005 SHALL have parameter SYNC_STAGES, default 2, lock synchroniser depth (>=2).
REQ-006 SHALL have parameter LOSS_W, default 8, width of lock-loss event counter.
REQ-007 SHALL have port clk_in  input  1  the single clock for all logic.
REQ-008 SHALL have port rst_in  input  1  asynchronous, active-high reset.
REQ-009 SHALL have port pll_lock  input  1  PLL lock, asynchronous to clk_in.
REQ-010 SHALL have port sw_rst_req  input  1  single-cycle software reset request.
REQ-011 SHALL have port clr_flag  input  1  single-cycle clear of lock_lost.
REQ-012 SHALL have port rst_out  output  N_CH  per-channel active-high reset, bit 0 released first.
REQ-013 SHALL have port ready  output  1  high when all channels are released.
REQ-014 SHALL have port lock_lost  output  1  sticky lock-loss flag.
REQ-015 SHALL have port loss_cnt  output  LOSS_W  saturating count of lock-loss events.

Function
REQ-016 SHALL pass pll_lock through a SYNC_STAGES flip-flop synchroniser; lock_s denotes the last stage; no other logic SHALL sample pll_lock.
REQ-017 SHALL implement states WAIT_LOCK, STRETCH, RELEASE, RUN; all outputs registered.
REQ-018 WAIT_LOCK: filter counter increments each edge lock_s=1, clears on lock_s=0; on reaching LOCK_FILT go to STRETCH with stretch counter cleared.
REQ-019 STRETCH: rst_out all ones; after STRETCH edges go to RELEASE and deassert rst_out[0] on the same edge.
REQ-020 RELEASE: rst_out[i] deasserts exactly GAP edges after rst_out[i-1]; once deasserted a bit stays low until re-entry to WAIT_LOCK or STRETCH.
REQ-021 On the edge rst_out[N_CH-1] deasserts, state SHALL become RUN and ready SHALL rise on that same edge; for N_CH=1 this is the rst_out[0] edge.
REQ-022 Timing: with t0 = first edge lock_s=1 and lock_s held high, rst_out[i] SHALL be low after edge t0+LOCK_FILT+STRETCH+i*GAP.
REQ-023 lock_s=0 in STRETCH, RELEASE or RUN SHALL on the next edge set rst_out all ones, ready=0, clear all counters, enter WAIT_LOCK.
REQ-024 A lock drop from RUN or RELEASE SHALL set lock_lost and increment loss_cnt (saturating at 2^LOSS_W-1); a drop in STRETCH SHALL NOT count.
REQ-025 sw_rst_req=1 in RUN with lock_s=1 SHALL on the next edge set rst_out all ones, ready=0, enter STRETCH (no lock re-qualification); no lock_lost/loss_cnt change.
REQ-026 sw_rst_req outside RUN SHALL be ignored.
REQ-027 Simultaneous lock_s=0 and sw_rst_req=1 in RUN: lock drop SHALL take precedence (WAIT_LOCK, counted).
REQ-028 clr_flag=1 SHALL clear lock_lost next edge; if a counted lock drop occurs in the same cycle lock_lost SHALL be set (set wins); loss_cnt is never cleared except by rst_in.

Reset
REQ-029 rst_in=1 SHALL asynchronously force rst_out all ones, ready=0, lock_lost=0, loss_cnt=0, synchroniser stages 0, all counters 0, state WAIT_LOCK.
REQ-030 rst_in assertion mid-sequence SHALL abort immediately; release SHALL restart from WAIT_LOCK; deassertion of rst_out SHALL only ever occur on a clk_in edge.

Verification
REQ-031 Defaults, pll_lock=1 steady, release rst_in -> rst_out[0..3] fall at t0+24, +28, +32, +36; ready rises at t0+36; lock_lost=0.
REQ-032 pll_lock glitches low 1 cycle at filter count 10 -> filter restarts; rst_out[0] falls 24 edges after lock_s returns high.
REQ-033 In RUN, drop pll_lock -> SYNC_STAGES+1 edges later rst_out=4'hF, ready=0, lock_lost=1, loss_cnt=1; relock resequences per REQ-022.
REQ-034 In RUN, sw_rst_req pulse -> next edge rst_out=4'hF; rst_out[0] falls 8 edges later, ready 12 edges after that; loss_cnt unchanged.
REQ-035 LOSS_W=2, five lock drops in RUN -> loss_cnt=3; clr_flag coincident with sixth drop -> lock_lost stays 1.
REQ-036 rst_in pulsed during RELEASE with rst_out=4'b1100 -> rst_out=4'hF asynchronously, loss_cnt=0, full resequence follows.

Source files
------------

// File: rtl/rst_seq.sv
// rst_seq: PLL-lock qualified, staggered multi-channel reset sequencer.
// Holds all channels in reset until lock is stable, then releases them in order.
module rst_seq #(
  parameter int N_CH        = 4,
  parameter int LOCK_FILT   = 16,
  parameter int STRETCH     = 8,
  parameter int GAP         = 4,
  parameter int SYNC_STAGES = 2,
  parameter int LOSS_W      = 8
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              pll_lock,
  input  logic              sw_rst_req,
  input  logic              clr_flag,
  output logic [N_CH-1:0]   rst_out,
  output logic              ready,
  output logic              lock_lost,
  output logic [LOSS_W-1:0] loss_cnt
);

  typedef enum logic [1:0] {
    S_WAIT_LOCK,
    S_STRETCH,
    S_RELEASE,
    S_RUN
  } state_t;

  localparam int FW = $clog2(LOCK_FILT + 1);
  localparam int SW = $clog2(STRETCH + 1);
  localparam int GW = $clog2(GAP + 1);

  localparam logic [FW-1:0]     FILT_MAX = FW'(LOCK_FILT);
  localparam logic [SW-1:0]     STR_LAST = SW'(STRETCH - 1);
  localparam logic [GW-1:0]     GAP_LAST = GW'(GAP - 1);
  localparam logic [LOSS_W-1:0] LOSS_MAX = '1;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   lock_s;

  state_t              state_q, state_d;
  logic [FW-1:0]       filt_q, filt_d;
  logic [SW-1:0]       str_q, str_d;
  logic [GW-1:0]       gap_q, gap_d;
  logic [N_CH-1:0]     rst_q, rst_d;
  logic                ready_q, ready_d;
  logic                lost_q, lost_d;
  logic [LOSS_W-1:0]   cnt_q, cnt_d;

  logic                drop;
  logic                counted;
  logic [N_CH-1:0]     rel_nxt;

  // Lock synchroniser; the only logic that samples pll_lock.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pll_lock};
    end
  end

  assign lock_s = sync_q[SYNC_STAGES-1];

  // A drop outside WAIT_LOCK aborts; only RELEASE/RUN drops are events.
  assign drop    = !lock_s && (state_q != S_WAIT_LOCK);
  assign counted = !lock_s &&
                   ((state_q == S_RELEASE) || (state_q == S_RUN));

  // Releasing the next channel clears the lowest still-set bit.
  assign rel_nxt = rst_q << 1;

  // Sequencer next-state and registered-output values.
  always_comb begin
    state_d = state_q;
    filt_d  = filt_q;
    str_d   = str_q;
    gap_d   = gap_q;
    rst_d   = rst_q;
    ready_d = ready_q;
    lost_d  = lost_q;
    cnt_d   = cnt_q;

    if (drop) begin
      state_d = S_WAIT_LOCK;
      filt_d  = '0;
      str_d   = '0;
      gap_d   = '0;
      rst_d   = '1;
      ready_d = 1'b0;
    end else begin
      unique case (state_q)
        S_WAIT_LOCK: begin
          rst_d   = '1;
          ready_d = 1'b0;
          if (!lock_s) begin
            filt_d = '0;
          end else if (filt_q == FILT_MAX) begin
            state_d = S_STRETCH;
            filt_d  = '0;
            str_d   = '0;
          end else begin
            filt_d = filt_q + FW'(1);
          end
        end
        S_STRETCH: begin
          if (str_q == STR_LAST) begin
            str_d = '0;
            gap_d = '0;
            rst_d = rel_nxt;
            if (rel_nxt == '0) begin
              state_d = S_RUN;
              ready_d = 1'b1;
            end else begin
              state_d = S_RELEASE;
            end
          end else begin
            str_d = str_q + SW'(1);
          end
        end
        S_RELEASE: begin
          if (gap_q == GAP_LAST) begin
            gap_d = '0;
            rst_d = rel_nxt;
            if (rel_nxt == '0) begin
              state_d = S_RUN;
              ready_d = 1'b1;
            end
          end else begin
            gap_d = gap_q + GW'(1);
          end
        end
        S_RUN: begin
          if (sw_rst_req) begin
            state_d = S_STRETCH;
            str_d   = '0;
            rst_d   = '1;
            ready_d = 1'b0;
          end
        end
        default: begin
          state_d = S_WAIT_LOCK;
          rst_d   = '1;
          ready_d = 1'b0;
        end
      endcase
    end

    if (counted) begin
      lost_d = 1'b1;
    end else if (clr_flag) begin
      lost_d = 1'b0;
    end

    if (counted && (cnt_q != LOSS_MAX)) begin
      cnt_d = cnt_q + LOSS_W'(1);
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= S_WAIT_LOCK;
      filt_q  <= '0;
      str_q   <= '0;
      gap_q   <= '0;
      rst_q   <= '1;
      ready_q <= 1'b0;
      lost_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      filt_q  <= filt_d;
      str_q   <= str_d;
      gap_q   <= gap_d;
      rst_q   <= rst_d;
      ready_q <= ready_d;
      lost_q  <= lost_d;
      cnt_q   <= cnt_d;
    end
  end

  assign rst_out   = rst_q;
  assign ready     = ready_q;
  assign lock_lost = lost_q;
  assign loss_cnt  = cnt_q;

endmodule

// File: tb/tb_rst_seq.sv
// tb_rst_seq: directed bench for rst_seq against an elapsed-time model.
// Two instances: default parameters and LOSS_W=2 for saturation.
module tb_rst_seq;

  localparam int N    = 4;
  localparam int LF   = 16;
  localparam int ST   = 8;
  localparam int GP   = 4;
  localparam int SS   = 2;
  localparam int REL0 = LF + ST;
  localparam int RDYE = LF + ST + (N - 1) * GP;

  logic       clk_in;
  logic       rst_in;
  logic       pll_lock;
  logic       sw_rst_req;
  logic       clr_flag;
  logic [3:0] rst_out_a, rst_out_b;
  logic       ready_a, ready_b;
  logic       lost_a, lost_b;
  logic [7:0] cnt_a;
  logic [1:0] cnt_b;

  int checks = 0;
  int errors = 0;
  bit run_cmp = 0;

  rst_seq u_dut_a (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .pll_lock  (pll_lock),
    .sw_rst_req(sw_rst_req),
    .clr_flag  (clr_flag),
    .rst_out   (rst_out_a),
    .ready     (ready_a),
    .lock_lost (lost_a),
    .loss_cnt  (cnt_a)
  );

  rst_seq #(.LOSS_W(2)) u_dut_b (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .pll_lock  (pll_lock),
    .sw_rst_req(sw_rst_req),
    .clr_flag  (clr_flag),
    .rst_out   (rst_out_b),
    .ready     (ready_b),
    .lock_lost (lost_b),
    .loss_cnt  (cnt_b)
  );

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  // Model: m_e = edges since the current unbroken run of lock began
  // (-1 = none). Channel i is released once m_e >= REL0 + i*GP.
  bit samp [0:8191];
  int n_ed;
  int m_e;
  bit m_lost;
  int m_drops;
  wire ls_m  = (n_ed >= SS) ? samp[n_ed - SS] : 1'b0;
  wire cnt_m = !ls_m && (m_e >= REL0);

  always @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      n_ed    <= 0;
      m_e     <= -1;
      m_lost  <= 1'b0;
      m_drops <= 0;
    end else begin
      samp[n_ed] <= pll_lock;
      n_ed       <= n_ed + 1;
      m_e        <= !ls_m ? -1 :
                    (sw_rst_req && (m_e >= RDYE)) ? LF : m_e + 1;
      m_lost     <= cnt_m ? 1'b1 : (clr_flag ? 1'b0 : m_lost);
      m_drops    <= m_drops + (cnt_m ? 1 : 0);
    end
  end

  function automatic logic [3:0] exp_rst(int e);
    logic [3:0] r;
    for (int i = 0; i < N; i++) r[i] = (e < REL0 + i * GP);
    return r;
  endfunction

  function automatic int sat(int v, int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic pin(input string nm, input logic [3:0] r, input logic rdy);
    chk({nm, " rst_a"}, 32'(rst_out_a), 32'(r));
    chk({nm, " rst_b"}, 32'(rst_out_b), 32'(r));
    chk({nm, " rdy_a"}, 32'(ready_a), 32'(rdy));
    chk({nm, " rdy_b"}, 32'(ready_b), 32'(rdy));
    chk({nm, " model_rst"}, 32'(exp_rst(m_e)), 32'(r));
  endtask

  task automatic flags(input string nm, input logic lst, input int ca,
                       input int cb);
    chk({nm, " lost_a"}, 32'(lost_a), 32'(lst));
    chk({nm, " lost_b"}, 32'(lost_b), 32'(lst));
    chk({nm, " cnt_a"}, 32'(cnt_a), 32'(ca));
    chk({nm, " cnt_b"}, 32'(cnt_b), 32'(cb));
    chk({nm, " model_lost"}, 32'(m_lost), 32'(lst));
    chk({nm, " model_cnt"}, 32'(sat(m_drops, 255)), 32'(ca));
  endtask

  // Per-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clk_in);
      if (run_cmp) begin
        chk("cyc rst_a", 32'(rst_out_a), 32'(exp_rst(m_e)));
        chk("cyc rst_b", 32'(rst_out_b), 32'(exp_rst(m_e)));
        chk("cyc rdy_a", 32'(ready_a), 32'(m_e >= RDYE));
        chk("cyc rdy_b", 32'(ready_b), 32'(m_e >= RDYE));
        chk("cyc lost_a", 32'(lost_a), 32'(m_lost));
        chk("cyc lost_b", 32'(lost_b), 32'(m_lost));
        chk("cyc cnt_a", 32'(cnt_a), 32'(sat(m_drops, 255)));
        chk("cyc cnt_b", 32'(cnt_b), 32'(sat(m_drops, 3)));
      end
    end
  end

  initial begin
    rst_in     = 1'b1;
    pll_lock   = 1'b0;
    sw_rst_req = 1'b0;
    clr_flag   = 1'b0;
    step(3);
    pin("reset", 4'hF, 1'b0);
    flags("reset", 1'b0, 0, 0);

    // Power-up with steady lock.
    pll_lock = 1'b1;
    step(2);
    rst_in  = 1'b0;
    run_cmp = 1'b1;
    step(26);
    pin("pwr pre", 4'hF, 1'b0);
    step(1);
    pin("pwr ch0", 4'hE, 1'b0);
    step(4);
    pin("pwr ch1", 4'hC, 1'b0);
    step(4);
    pin("pwr ch2", 4'h8, 1'b0);
    step(4);
    pin("pwr run", 4'h0, 1'b1);
    flags("pwr", 1'b0, 0, 0);

    // Lock glitch at filter count 10.
    rst_in = 1'b1;
    step(1);
    rst_in = 1'b0;
    step(10);
    pll_lock = 1'b0;
    step(1);
    pll_lock = 1'b1;
    step(26);
    pin("glitch pre", 4'hF, 1'b0);
    step(1);
    pin("glitch ch0", 4'hE, 1'b0);
    step(12);
    pin("glitch run", 4'h0, 1'b1);

    // Lock drop in RUN, then relock.
    pll_lock = 1'b0;
    step(2);
    pin("drop hold", 4'h0, 1'b1);
    step(1);
    pin("drop", 4'hF, 1'b0);
    flags("drop", 1'b1, 1, 1);
    pll_lock = 1'b1;
    step(26);
    pin("relock pre", 4'hF, 1'b0);
    step(1);
    pin("relock ch0", 4'hE, 1'b0);
    step(12);
    pin("relock run", 4'h0, 1'b1);

    // Software reset, plus an ignored request in STRETCH.
    sw_rst_req = 1'b1;
    step(1);
    sw_rst_req = 1'b0;
    pin("sw", 4'hF, 1'b0);
    step(2);
    sw_rst_req = 1'b1;
    step(1);
    sw_rst_req = 1'b0;
    step(4);
    pin("sw pre", 4'hF, 1'b0);
    step(1);
    pin("sw ch0", 4'hE, 1'b0);
    step(12);
    pin("sw run", 4'h0, 1'b1);
    flags("sw", 1'b1, 1, 1);
    clr_flag = 1'b1;
    step(1);
    clr_flag = 1'b0;
    flags("clr", 1'b0, 1, 1);

    // Drop during STRETCH is not an event.
    sw_rst_req = 1'b1;
    step(1);
    sw_rst_req = 1'b0;
    pll_lock   = 1'b0;
    step(3);
    pin("str drop", 4'hF, 1'b0);
    flags("str drop", 1'b0, 1, 1);
    pll_lock = 1'b1;
    step(39);
    pin("str relock", 4'h0, 1'b1);

    // Four more drops; the first with a coincident sw request.
    for (int k = 0; k < 4; k++) begin
      pll_lock = 1'b0;
      step(2);
      if (k == 0) sw_rst_req = 1'b1;
      step(1);
      sw_rst_req = 1'b0;
      pll_lock   = 1'b1;
      pin("multi drop", 4'hF, 1'b0);
      step(39);
      pin("multi run", 4'h0, 1'b1);
    end
    flags("five drops", 1'b1, 5, 3);

    // Clear, then sixth drop with coincident clear.
    clr_flag = 1'b1;
    step(1);
    clr_flag = 1'b0;
    flags("clr2", 1'b0, 5, 3);
    pll_lock = 1'b0;
    step(2);
    clr_flag = 1'b1;
    step(1);
    clr_flag = 1'b0;
    pll_lock = 1'b1;
    flags("set wins", 1'b1, 6, 3);
    step(39);
    pin("sixth run", 4'h0, 1'b1);

    // Asynchronous reset during RELEASE.
    sw_rst_req = 1'b1;
    step(1);
    sw_rst_req = 1'b0;
    step(12);
    pin("rel 1100", 4'hC, 1'b0);
    #2;
    rst_in = 1'b1;
    #1;
    pin("async rst", 4'hF, 1'b0);
    flags("async rst", 1'b0, 0, 0);
    step(1);
    rst_in = 1'b0;
    step(26);
    pin("reseq pre", 4'hF, 1'b0);
    step(1);
    pin("reseq ch0", 4'hE, 1'b0);
    step(12);
    pin("reseq run", 4'h0, 1'b1);
    flags("reseq", 1'b0, 0, 0);

    run_cmp = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
